// File: rtl/branch_predictor_pkg.sv
// Shared constants for the dynamic branch predictor.
//   CTR_*      2-bit saturating counter encodings (strongly/weakly not-taken/taken)
//   IDX_W_DEF  default BHT/BTB index width (table depth = 2**IDX_W_DEF)
package branch_predictor_pkg;
   localparam int         IDX_W_DEF = 5;
   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step, purely combinational.
//   ctr       current counter value
//   taken     resolved direction (1 = count up, 0 = count down)
//   ctr_next  next counter value; saturates at CTR_ST and CTR_SNT
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB plus 2-bit counter table for the RV32I core.
// IF side looks up the fetch PC combinationally and supplies the predicted next
// PC; EX side resolves the outcome, flags a misprediction with its redirect PC,
// and updates the entry captured at fetch (ex_idx).
// Build option: GSHARE_EN -- index is fetch PC bits XOR global history (ghr),
// history shifted non-speculatively at conditional-branch resolution.
// Ports:
//   clk, reset                 core clock, asynchronous active-high reset
//   if_pc                      fetch PC
//   pred_taken/pred_next_pc    prediction for if_pc
//   pred_idx                   table index used for the lookup
//   ex_valid/ex_is_ctrl/ex_is_jump  EX instruction qualifiers
//   ex_pc/ex_idx/ex_bcond/ex_target/ex_pred_next_pc  EX resolution inputs
//   mispredict/redirect_pc     resolution result
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = 32 - 2 - IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      if_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_next_pc,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             ex_valid,
   input  logic             ex_is_ctrl,
   input  logic             ex_is_jump,
   input  logic [31:0]      ex_pc,
   input  logic [IDX_W-1:0] ex_idx,
   input  logic             ex_bcond,
   input  logic [31:0]      ex_target,
   input  logic [31:0]      ex_pred_next_pc,
   output logic             mispredict,
   output logic [31:0]      redirect_pc
);
   localparam int DEPTH = 1 << IDX_W;

   // Flop arrays rather than SRAM so every entry clears on async reset.
   logic             tbl_valid  [DEPTH];
   logic [TAG_W-1:0] tbl_tag    [DEPTH];
   logic [31:0]      tbl_target [DEPTH];
   logic [1:0]       tbl_ctr    [DEPTH];

   logic [IDX_W-1:0] lk_idx;
   logic             lk_hit;
   logic             taken_act;
   logic [31:0]      act_next;
   logic             do_update;
   logic             ex_hit;
   logic [1:0]       ctr_upd;

`ifdef GSHARE_EN
   logic [IDX_W-1:0] ghr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr <= '0;
      end else if (do_update && !ex_is_jump) begin
         ghr <= {ghr[IDX_W-2:0], taken_act};
      end
   end

   assign lk_idx = if_pc[IDX_W+1:2] ^ ghr;
`else
   assign lk_idx = if_pc[IDX_W+1:2];
`endif

   // Lookup sees the pre-update table contents; no write-through bypass.
   assign lk_hit       = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == if_pc[31:IDX_W+2]);
   assign pred_taken   = lk_hit && tbl_ctr[lk_idx][1];
   assign pred_next_pc = pred_taken ? tbl_target[lk_idx] : if_pc + 32'd4;
   assign pred_idx     = lk_idx;

   assign taken_act   = ex_is_jump | ex_bcond;
   assign act_next    = taken_act ? ex_target : ex_pc + 32'd4;
   assign redirect_pc = act_next;
   assign mispredict  = ex_valid & ex_is_ctrl & (act_next != ex_pred_next_pc);

   assign do_update = ex_valid & ex_is_ctrl;
   assign ex_hit    = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_pc[31:IDX_W+2]);

   sat_counter2 u_ctr (
      .ctr      (tbl_ctr[ex_idx]),
      .taken    (taken_act),
      .ctr_next (ctr_upd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_valid[i]  <= 1'b0;
            tbl_tag[i]    <= '0;
            tbl_target[i] <= '0;
            tbl_ctr[i]    <= CTR_WNT;
         end
      end else if (do_update) begin
         if (ex_hit) begin
            tbl_ctr[ex_idx] <= ctr_upd;
            if (taken_act) tbl_target[ex_idx] <= ex_target;
         end else if (taken_act) begin
            // Allocate only on taken; jumps start strongly taken.
            tbl_valid[ex_idx]  <= 1'b1;
            tbl_tag[ex_idx]    <= ex_pc[31:IDX_W+2];
            tbl_target[ex_idx] <= ex_target;
            tbl_ctr[ex_idx]    <= ex_is_jump ? CTR_ST : CTR_WT;
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
   logic        clk;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic [4:0]  pred_idx;
   logic        ex_valid;
   logic        ex_is_ctrl;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic [4:0]  ex_idx;
   logic        ex_bcond;
   logic [31:0] ex_target;
   logic [31:0] ex_pred_next_pc;
   logic        mispredict;
   logic [31:0] redirect_pc;

   int n_vec  = 0;
   int n_miss = 0;

   branch_predictor dut (
      .clk             (clk),
      .reset           (reset),
      .if_pc           (if_pc),
      .pred_taken      (pred_taken),
      .pred_next_pc    (pred_next_pc),
      .pred_idx        (pred_idx),
      .ex_valid        (ex_valid),
      .ex_is_ctrl      (ex_is_ctrl),
      .ex_is_jump      (ex_is_jump),
      .ex_pc           (ex_pc),
      .ex_idx          (ex_idx),
      .ex_bcond        (ex_bcond),
      .ex_target       (ex_target),
      .ex_pred_next_pc (ex_pred_next_pc),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ex_valid   = 1'b0;
      ex_is_ctrl = 1'b0;
      ex_is_jump = 1'b0;
      ex_bcond   = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_n,
                       input string nm);
      if_pc = pc;
      #1;
      check_vec({nm, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
      check_vec({nm, "_next"}, pred_next_pc, exp_n);
   endtask

   // Drive one EX instruction, check resolution outputs, then clock the update.
   task automatic resolve(input logic v, input logic ctrl, input logic jmp,
                          input logic [31:0] pc, input logic [4:0] idx, input logic bc,
                          input logic [31:0] tgt, input logic [31:0] pn,
                          input logic exp_mp, input logic [31:0] exp_rd, input string nm);
      ex_valid        = v;
      ex_is_ctrl      = ctrl;
      ex_is_jump      = jmp;
      ex_pc           = pc;
      ex_idx          = idx;
      ex_bcond        = bc;
      ex_target       = tgt;
      ex_pred_next_pc = pn;
      #1;
      check_vec({nm, "_mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
      check_vec({nm, "_redirect"}, redirect_pc, exp_rd);
      step();
   endtask

   initial begin
      reset = 1'b1;
      if_pc = 32'h100;
      ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_is_jump = 1'b0; ex_bcond = 1'b0;
      ex_pc = '0; ex_idx = '0; ex_target = '0; ex_pred_next_pc = '0;
      #1;
      check_vec("in_reset_taken", {31'd0, pred_taken}, 32'd0);
      check_vec("in_reset_next", pred_next_pc, 32'h104);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

`ifndef GSHARE_EN
      look(32'h100, 1'b0, 32'h104, "post_reset");
      check_vec("post_reset_idx", {27'd0, pred_idx}, 32'd0);

      // Taken BEQ allocates; same-cycle lookup still sees the old (empty) entry.
      ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_is_jump = 1'b0; ex_pc = 32'h100; ex_idx = 5'd0;
      ex_bcond = 1'b1; ex_target = 32'h80; ex_pred_next_pc = 32'h104; if_pc = 32'h100;
      #1;
      check_vec("beq_mispredict", {31'd0, mispredict}, 32'd1);
      check_vec("beq_redirect", redirect_pc, 32'h80);
      check_vec("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
      step();
      look(32'h100, 1'b1, 32'h80, "beq_alloc");

      // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10
      resolve(1, 1, 0, 32'h100, 5'd0, 0, 32'h80, 32'h80, 1'b1, 32'h104, "nt1");
      look(32'h100, 1'b0, 32'h104, "ctr01");
      resolve(1, 1, 0, 32'h100, 5'd0, 0, 32'h80, 32'h104, 1'b0, 32'h104, "nt2");
      resolve(1, 1, 0, 32'h100, 5'd0, 0, 32'h80, 32'h104, 1'b0, 32'h104, "nt3");
      resolve(1, 1, 0, 32'h100, 5'd0, 1, 32'h80, 32'h104, 1'b1, 32'h80, "t_after_sat");
      look(32'h100, 1'b0, 32'h104, "no_wrap_ctr01");
      resolve(1, 1, 0, 32'h100, 5'd0, 1, 32'h80, 32'h104, 1'b1, 32'h80, "t2");
      look(32'h100, 1'b1, 32'h80, "ctr10");

      // Non-control instruction: never mispredicts and never updates.
      resolve(1, 0, 0, 32'h100, 5'd0, 0, 32'h999, 32'h0, 1'b0, 32'h104, "nonctrl");
      look(32'h100, 1'b1, 32'h80, "nonctrl_noupd");

      // Aliasing: 0x180 maps to idx 0 with a different tag and replaces it.
      resolve(1, 1, 0, 32'h180, 5'd0, 1, 32'h40, 32'h184, 1'b1, 32'h40, "alias");
      look(32'h100, 1'b0, 32'h104, "alias_old_miss");
      look(32'h180, 1'b1, 32'h40, "alias_new_hit");
      // Tag miss, not taken: entry untouched.
      resolve(1, 1, 0, 32'h100, 5'd0, 0, 32'h80, 32'h104, 1'b0, 32'h104, "miss_nt");
      look(32'h180, 1'b1, 32'h40, "miss_nt_keep");

      // JALR allocates strongly taken; a bubble must not touch the table.
      resolve(1, 1, 1, 32'h200, 5'd0, 0, 32'h1000, 32'h1000, 1'b0, 32'h1000, "jalr");
      look(32'h200, 1'b1, 32'h1000, "jalr_alloc");
      resolve(0, 1, 0, 32'h200, 5'd0, 0, 32'h1000, 32'h1000, 1'b0, 32'h204, "bubble");
      resolve(1, 1, 0, 32'h200, 5'd0, 0, 32'h1000, 32'h1000, 1'b1, 32'h204, "jalr_nt");
      look(32'h200, 1'b1, 32'h1000, "ctr11_then_10");

      // PC wraparound.
      look(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap");
      check_vec("wrap_idx", {27'd0, pred_idx}, 32'h1F);
      resolve(1, 1, 0, 32'hFFFF_FFFC, 5'h1F, 0, 32'h10, 32'h0, 1'b0, 32'h0, "wrap_ex");

      // Async reset mid-operation clears at once and drops the pending update.
      if_pc = 32'h200;
      #2;
      reset = 1'b1;
      #1;
      check_vec("async_reset_taken", {31'd0, pred_taken}, 32'd0);
      check_vec("async_reset_next", pred_next_pc, 32'h204);
      ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_pc = 32'h300; ex_idx = 5'd0;
      ex_bcond = 1'b1; ex_target = 32'h500; ex_pred_next_pc = 32'h304;
      step();
      reset = 1'b0;
      look(32'h300, 1'b0, 32'h304, "reset_drops_upd");
`else
      if_pc = 32'h100;
      #1;
      check_vec("gs_idx0", {27'd0, pred_idx}, 32'h00);
      resolve(1, 1, 0, 32'h100, 5'd0, 1, 32'h80, 32'h104, 1'b1, 32'h80, "gs_t1");
      if_pc = 32'h100;
      #1;
      check_vec("gs_idx1", {27'd0, pred_idx}, 32'h01);
      check_vec("gs_idx1_taken", {31'd0, pred_taken}, 32'd0);
      look(32'h104, 1'b1, 32'h80, "gs_xor_hit");
      resolve(1, 1, 0, 32'h104, 5'd0, 1, 32'h80, 32'h80, 1'b0, 32'h80, "gs_t2");
      resolve(1, 1, 0, 32'h104, 5'd0, 0, 32'h80, 32'h80, 1'b1, 32'h108, "gs_n3");
      if_pc = 32'h100;
      #1;
      check_vec("gs_idx6", {27'd0, pred_idx}, 32'h06);
      resolve(1, 1, 1, 32'h400, 5'd5, 0, 32'h800, 32'h404, 1'b1, 32'h800, "gs_jump");
      resolve(0, 1, 0, 32'h100, 5'd6, 1, 32'h80, 32'h104, 1'b0, 32'h80, "gs_bubble");
      if_pc = 32'h100;
      #1;
      check_vec("gs_idx6_kept", {27'd0, pred_idx}, 32'h06);
      look(32'h118, 1'b1, 32'h80, "gs_entry0");
      #2;
      reset = 1'b1;
      #1;
      if_pc = 32'h100;
      #1;
      check_vec("gs_reset_idx", {27'd0, pred_idx}, 32'h00);
      look(32'h118, 1'b0, 32'h11C, "gs_reset_miss");
      reset = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
